// File: rtl/biquad_df1.sv
// Direct-form-I biquad with one time-multiplexed multiplier (five MAC cycles per sample).
// Define BIQUAD_DF1_SAT_EN to clamp results to the signed BITWIDTH range instead of wrapping.
module biquad_df1 #(
  parameter int BITWIDTH = 32,
  parameter int COEFW    = 18,
  parameter int FRAC     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] sig_in,
  input  logic signed [COEFW-1:0]    b0,
  input  logic signed [COEFW-1:0]    b1,
  input  logic signed [COEFW-1:0]    b2,
  input  logic signed [COEFW-1:0]    a1,
  input  logic signed [COEFW-1:0]    a2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] sig_out
);

  localparam int PRODW = BITWIDTH + COEFW;
  localparam int ACCW  = BITWIDTH + COEFW + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic signed [BITWIDTH-1:0] x0_r, x1_r, x2_r, y1_r, y2_r;
  logic signed [COEFW-1:0]    b0_r, b1_r, b2_r, a1_r, a2_r;
  logic signed [ACCW-1:0]     acc_r;
  logic [2:0]                 tap_r;

  logic signed [COEFW-1:0]    mul_coef_s;
  logic signed [BITWIDTH-1:0] mul_samp_s;
  logic                       mul_neg_s;
  logic signed [PRODW-1:0]    product_s;
  logic signed [ACCW-1:0]     prod_ext_s;
  logic signed [ACCW-1:0]     term_s;
  logic signed [BITWIDTH-1:0] result_s;

  // Operand select for the shared multiplier; feedback taps are subtracted.
  always_comb begin
    mul_coef_s = '0;
    mul_samp_s = '0;
    mul_neg_s  = 1'b0;
    case (tap_r)
      3'd0: begin mul_coef_s = b0_r; mul_samp_s = x0_r; end
      3'd1: begin mul_coef_s = b1_r; mul_samp_s = x1_r; end
      3'd2: begin mul_coef_s = b2_r; mul_samp_s = x2_r; end
      3'd3: begin mul_coef_s = a1_r; mul_samp_s = y1_r; mul_neg_s = 1'b1; end
      3'd4: begin mul_coef_s = a2_r; mul_samp_s = y2_r; mul_neg_s = 1'b1; end
      default: begin mul_coef_s = '0; mul_samp_s = '0; mul_neg_s = 1'b0; end
    endcase
  end

  // Negation happens at accumulator width so the most negative product cannot overflow.
  always_comb begin
    product_s  = mul_coef_s * mul_samp_s;
    prod_ext_s = ACCW'(product_s);
    if (mul_neg_s) begin
      term_s = -prod_ext_s;
    end else begin
      term_s = prod_ext_s;
    end
  end

`ifdef BIQUAD_DF1_SAT_EN
  logic signed [ACCW-1:0] shifted_s;
  logic signed [ACCW-1:0] max_s;
  logic signed [ACCW-1:0] min_s;

  // Arithmetic shift then clamp to the representable output range.
  always_comb begin
    shifted_s = acc_r >>> FRAC;
    max_s     = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    min_s     = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
    if (shifted_s > max_s) begin
      result_s = {1'b0, {(BITWIDTH-1){1'b1}}};
    end else if (shifted_s < min_s) begin
      result_s = {1'b1, {(BITWIDTH-1){1'b0}}};
    end else begin
      result_s = shifted_s[BITWIDTH-1:0];
    end
  end
`else
  // Low BITWIDTH bits of the shifted accumulator: plain two's-complement wrap.
  always_comb begin
    result_s = acc_r[FRAC+BITWIDTH-1:FRAC];
  end
`endif

  // Next-state logic; in_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    state_next_s = state_r;
    in_ready     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          state_next_s = MAC;
        end else begin
          state_next_s = IDLE;
        end
      end
      MAC: begin
        if (tap_r == 3'd5) begin
          state_next_s = OUT;
        end else begin
          state_next_s = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: begin
        state_next_s = IDLE;
        in_ready     = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: latch on accept, accumulate taps 0..4, then commit result and shift history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_r <= '0; x1_r <= '0; x2_r <= '0; y1_r <= '0; y2_r <= '0;
      b0_r <= '0; b1_r <= '0; b2_r <= '0; a1_r <= '0; a2_r <= '0;
      acc_r     <= '0;
      tap_r     <= 3'd0;
      sig_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x0_r  <= sig_in;
            b0_r  <= b0; b1_r <= b1; b2_r <= b2; a1_r <= a1; a2_r <= a2;
            acc_r <= '0;
            tap_r <= 3'd0;
          end
        end
        MAC: begin
          if (tap_r == 3'd5) begin
            sig_out   <= result_s;
            out_valid <= 1'b1;
            x2_r      <= x1_r;
            x1_r      <= x0_r;
            y2_r      <= y1_r;
            y1_r      <= result_s;
          end else begin
            acc_r <= acc_r + term_s;
            tap_r <= tap_r + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
